// File: rtl/pattern_out_gen_if.sv
// Control/status bundle between the top-level wrapper and the output-pattern generator.
// The master drives the controls; the slave (the generator) returns the registered pattern.
interface pattern_out_gen_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV_W = 16
);
    logic             en;
    logic [1:0]       mode;
    logic [DIV_W-1:0] div;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] pat_out;
    logic [WIDTH-1:0] pat_oe;
    logic             tick;

    modport master (
        output en, mode, div, load, load_value,
        input  pat_out, pat_oe, tick
    );

    modport slave (
        input  en, mode, div, load, load_value,
        output pat_out, pat_oe, tick
    );
endinterface

// File: rtl/pattern_out_gen.sv
// Registered output-pattern generator: constant, binary count, walking one or toggle,
// advanced by a programmable prescaler tick.
module pattern_out_gen #(
    parameter int unsigned         WIDTH         = 8,
    parameter int unsigned         DIV_W         = 16,
    parameter logic [WIDTH-1:0]    DEFAULT_VALUE = 8'hFF
) (
    input  logic              clk,
    input  logic              reset,
    pattern_out_gen_if.slave  bus
);

    localparam logic [1:0] ModeConst  = 2'd0;
    localparam logic [1:0] ModeCount  = 2'd1;
    localparam logic [1:0] ModeWalk   = 2'd2;
    localparam logic [1:0] ModeToggle = 2'd3;

    logic [WIDTH-1:0] pat_q, pat_d;
    logic [WIDTH-1:0] oe_q, oe_d;
    logic             tick_q, tick_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] pat_next;

    always_comb begin
        pat_next = pat_q;
        case (mode_q)
            ModeConst:  pat_next = pat_q;
            ModeCount:  pat_next = pat_q + 1'b1;
            ModeWalk: begin
                if (pat_q == '0) begin
                    pat_next = {{(WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    pat_next = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
                end
            end
            ModeToggle: pat_next = ~pat_q;
            default:    pat_next = pat_q;
        endcase
    end

    // Priority: load, then mode change, then the prescaler. A mode change restarts the
    // prescaler so the new mode gets a full period before its first advance.
    always_comb begin
        pat_d  = pat_q;
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        oe_d   = {WIDTH{bus.en}};
        mode_d = bus.mode;
        if (bus.load) begin
            pat_d = bus.load_value;
            cnt_d = '0;
        end else if (bus.mode != mode_q) begin
            cnt_d = '0;
        end else if (bus.en) begin
            if (cnt_q == bus.div) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                pat_d  = pat_next;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q  <= DEFAULT_VALUE;
            oe_q   <= '0;
            tick_q <= 1'b0;
            cnt_q  <= '0;
            mode_q <= ModeConst;
        end else begin
            pat_q  <= pat_d;
            oe_q   <= oe_d;
            tick_q <= tick_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
        end
    end

    assign bus.pat_out = pat_q;
    assign bus.pat_oe  = oe_q;
    assign bus.tick    = tick_q;

endmodule

// File: tb/tb_pattern_out_gen.sv
// Self-checking bench for pattern_out_gen: directed scenarios plus a randomized run
// compared against a cycle-level reference model.
module tb_pattern_out_gen;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    // Reference model state (plain integers).
    int m_pat;
    int m_oe;
    int m_tick;
    int m_cnt;
    int m_mode;

    pattern_out_gen_if #(.WIDTH(8), .DIV_W(16)) bus ();

    pattern_out_gen #(
        .WIDTH         (8),
        .DIV_W         (16),
        .DEFAULT_VALUE (8'hFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int advance(input int p, input int m);
        case (m)
            1: return (p + 1) % 256;
            2: return (p == 0) ? 1 : (((p * 2) % 256) + (p / 128));
            3: return 255 - p;
            default: return p;
        endcase
    endfunction

    // One clock edge; the model consumes the inputs that the DUT samples at that edge.
    task automatic cyc();
        int old_mode;
        @(posedge clk);
        if (reset) begin
            m_pat = 255; m_oe = 0; m_tick = 0; m_cnt = 0; m_mode = 0;
        end else begin
            old_mode = m_mode;
            m_mode   = int'(bus.mode);
            m_oe     = bus.en ? 255 : 0;
            m_tick   = 0;
            if (bus.load) begin
                m_pat = int'(bus.load_value);
                m_cnt = 0;
            end else if (int'(bus.mode) != old_mode) begin
                m_cnt = 0;
            end else if (bus.en) begin
                if (m_cnt == int'(bus.div)) begin
                    m_cnt  = 0;
                    m_tick = 1;
                    m_pat  = advance(m_pat, m_mode);
                end else begin
                    m_cnt = (m_cnt + 1) % 65536;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.en = 1'b0; bus.mode = 2'd0; bus.div = '0; bus.load = 1'b0; bus.load_value = '0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_checks++;
            if (bus.pat_out !== 8'hFF || bus.pat_oe !== 8'h00 || bus.tick !== 1'b0) begin
                n_errors++;
                $display("FAIL reset cyc%0d: pat=%h oe=%h tick=%b, expected pat=ff oe=00 tick=0",
                         i, bus.pat_out, bus.pat_oe, bus.tick);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_count();
        logic [7:0] exp_seq [4];
        exp_seq[0] = 8'hFE; exp_seq[1] = 8'hFF; exp_seq[2] = 8'h00; exp_seq[3] = 8'h01;
        bus.load = 1'b1; bus.load_value = 8'hFE; bus.mode = 2'd1; bus.div = 16'd0; bus.en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            bus.load = 1'b0;
            n_checks++;
            if (bus.pat_out !== exp_seq[i] || bus.tick !== (i != 0) || bus.pat_oe !== 8'hFF) begin
                n_errors++;
                $display("FAIL count step%0d: pat=%h tick=%b oe=%h, expected pat=%h tick=%b oe=ff",
                         i, bus.pat_out, bus.tick, bus.pat_oe, exp_seq[i], i != 0);
            end
        end
    endtask

    task automatic test_walk();
        logic [7:0] exp_pat;
        bus.en = 1'b0; bus.mode = 2'd2; bus.div = 16'd2; bus.load = 1'b1; bus.load_value = 8'h00;
        cyc();
        bus.load = 1'b0; bus.en = 1'b1;
        exp_pat = 8'h00;
        for (int a = 0; a < 9; a++) begin
            for (int c = 0; c < 3; c++) begin
                cyc();
                if (c == 2) exp_pat = 8'(1 << (a % 8));
                n_checks++;
                if (bus.pat_out !== exp_pat || bus.tick !== (c == 2)) begin
                    n_errors++;
                    $display("FAIL walk adv%0d cyc%0d: pat=%h tick=%b, expected pat=%h tick=%b",
                             a, c, bus.pat_out, bus.tick, exp_pat, c == 2);
                end
            end
        end
    endtask

    task automatic test_toggle_pause();
        bus.mode = 2'd3; bus.div = 16'd1; bus.load = 1'b1; bus.load_value = 8'hA5; bus.en = 1'b1;
        cyc();
        bus.load = 1'b0;
        cyc();
        n_checks++;
        if (bus.pat_out !== 8'hA5 || bus.tick !== 1'b0) begin
            n_errors++;
            $display("FAIL toggle first: pat=%h tick=%b, expected a5/0", bus.pat_out, bus.tick);
        end
        cyc();
        n_checks++;
        if (bus.pat_out !== 8'h5A || bus.tick !== 1'b1) begin
            n_errors++;
            $display("FAIL toggle adv: pat=%h tick=%b, expected 5a/1", bus.pat_out, bus.tick);
        end
        cyc();  // prescaler now one short of the next event
        bus.en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_checks++;
            if (bus.pat_out !== 8'h5A || bus.tick !== 1'b0 || bus.pat_oe !== 8'h00) begin
                n_errors++;
                $display("FAIL toggle paused%0d: pat=%h tick=%b oe=%h, expected 5a/0/00",
                         i, bus.pat_out, bus.tick, bus.pat_oe);
            end
        end
        bus.en = 1'b1;
        cyc();
        n_checks++;
        if (bus.pat_out !== 8'hA5 || bus.tick !== 1'b1 || bus.pat_oe !== 8'hFF) begin
            n_errors++;
            $display("FAIL toggle resume: pat=%h tick=%b oe=%h, expected a5/1/ff",
                     bus.pat_out, bus.tick, bus.pat_oe);
        end
    endtask

    task automatic test_load_event();
        bus.mode = 2'd1; bus.div = 16'd3; bus.load = 1'b1; bus.load_value = 8'h07; bus.en = 1'b1;
        cyc();
        bus.load = 1'b0;
        repeat (3) cyc();
        bus.load = 1'b1; bus.load_value = 8'h5C;  // coincides with the event cycle
        cyc();
        bus.load = 1'b0;
        n_checks++;
        if (bus.pat_out !== 8'h5C || bus.tick !== 1'b0) begin
            n_errors++;
            $display("FAIL load_on_event: pat=%h tick=%b, expected 5c/0", bus.pat_out, bus.tick);
        end
        for (int i = 1; i <= 4; i++) begin
            cyc();
            n_checks++;
            if (bus.tick !== (i == 4) || bus.pat_out !== ((i == 4) ? 8'h5D : 8'h5C)) begin
                n_errors++;
                $display("FAIL load_then_tick cyc%0d: pat=%h tick=%b", i, bus.pat_out, bus.tick);
            end
        end
    endtask

    task automatic test_mode_change();
        bus.mode = 2'd0; bus.div = 16'd2;
        repeat (3) cyc();
        bus.mode = 2'd1;
        cyc();
        n_checks++;
        if (bus.pat_out !== 8'h5D || bus.tick !== 1'b0) begin
            n_errors++;
            $display("FAIL mode_change edge: pat=%h tick=%b, expected 5d/0", bus.pat_out, bus.tick);
        end
        for (int i = 1; i <= 3; i++) begin
            cyc();
            n_checks++;
            if (bus.tick !== (i == 3) || bus.pat_out !== ((i == 3) ? 8'h5E : 8'h5D)) begin
                n_errors++;
                $display("FAIL mode_change cyc%0d: pat=%h tick=%b", i, bus.pat_out, bus.tick);
            end
        end
    endtask

    task automatic test_reset_mid();
        bus.mode = 2'd1; bus.div = 16'd4; bus.load = 1'b1; bus.load_value = 8'h3C; bus.en = 1'b1;
        cyc();
        bus.load = 1'b0;
        repeat (2) cyc();
        reset = 1'b1; bus.mode = 2'd0; bus.div = 16'd2;
        cyc();
        n_checks++;
        if (bus.pat_out !== 8'hFF || bus.pat_oe !== 8'h00 || bus.tick !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid: pat=%h oe=%h tick=%b, expected ff/00/0",
                     bus.pat_out, bus.pat_oe, bus.tick);
        end
        reset = 1'b0;
        // A cleared prescaler needs div+1 cycles before the first tick.
        for (int i = 1; i <= 3; i++) begin
            cyc();
            n_checks++;
            if (bus.tick !== (i == 3) || bus.pat_out !== 8'hFF) begin
                n_errors++;
                $display("FAIL reset_mid cnt cyc%0d: pat=%h tick=%b", i, bus.pat_out, bus.tick);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset  = ($urandom_range(0, 99) == 0);
            bus.en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) bus.mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) bus.div = 16'($urandom_range(0, 3));
            bus.load       = ($urandom_range(0, 14) == 0);
            bus.load_value = 8'($urandom_range(0, 255));
            cyc();
            n_checks++;
            if (bus.pat_out !== 8'(m_pat) || bus.pat_oe !== 8'(m_oe) || bus.tick !== (m_tick != 0))
            begin
                n_errors++;
                $display("FAIL random cyc%0d: pat=%h oe=%h tick=%b, expected pat=%h oe=%h tick=%0d",
                         i, bus.pat_out, bus.pat_oe, bus.tick, 8'(m_pat), 8'(m_oe), m_tick);
            end
        end
        reset = 1'b0;
        bus.load = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_pat = 255; m_oe = 0; m_tick = 0; m_cnt = 0; m_mode = 0;
        reset = 1'b1;
        bus.en = 1'b0; bus.mode = 2'd0; bus.div = '0; bus.load = 1'b0; bus.load_value = '0;
        test_reset();
        test_count();
        test_walk();
        test_toggle_pause();
        test_load_event();
        test_mode_change();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
